// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: round-robin between CPU ld/st and host loader,
// with a host-lock mode and an in-order fixed-latency read return.
module dmem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          host_lock,
    output logic          lock_ack,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] mem_in,
    output logic          memory_w_en,
    output logic          memory_r_en,
    input  logic [DW-1:0] mem_out,
    output logic          busy
);

    typedef enum logic [1:0] {ARB, DRAIN, LOCK} state_t;

    state_t state, state_nx;

    logic              last_host;
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0] po;
    logic [DW-1:0]     cpu_rd_q;
    logic [DW-1:0]     host_rd_q;
    logic              cpu_ok;
    logic              cpu_inflight;
    logic              rd_push;
    logic              out_v;

    // CPU may only win while arbitrating and no lock is being requested
    assign cpu_ok = init_n && (state == ARB) && !host_lock;

    assign cpu_gnt  = cpu_ok && cpu_req && !(host_req && !last_host);
    assign host_gnt = init_n && host_req && !(cpu_ok && cpu_req && last_host);

    assign cpu_inflight = |(pv & ~po);
    assign rd_push      = (cpu_gnt && !cpu_we) || (host_gnt && !host_we);

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state <= ARB;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARB: begin
                if (host_lock) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!host_lock)        state_nx = ARB;
                else if (!cpu_inflight) state_nx = LOCK;
            end
            LOCK: begin
                if (!host_lock) state_nx = ARB;
            end
            default: state_nx = ARB;
        endcase
    end

    always_comb begin
        addr        = '0;
        mem_in      = '0;
        memory_w_en = 1'b0;
        memory_r_en = 1'b0;
        if (cpu_gnt) begin
            addr        = cpu_addr;
            mem_in      = cpu_wdata;
            memory_w_en = cpu_we;
            memory_r_en = !cpu_we;
        end else if (host_gnt) begin
            addr        = host_addr;
            mem_in      = host_wdata;
            memory_w_en = host_we;
            memory_r_en = !host_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            last_host <= 1'b1;
        end else if (cpu_gnt) begin
            last_host <= 1'b0;
        end else if (host_gnt) begin
            last_host <= 1'b1;
        end
    end

    // Owner shift pipeline: po=1 marks a host-owned read
    always_ff @(posedge clk) begin
        if (!init_n) begin
            pv <= '0;
            po <= '0;
        end else begin
            pv[0] <= rd_push;
            po[0] <= host_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                po[i] <= po[i-1];
            end
        end
    end

    assign out_v       = init_n && pv[RD_LAT-1];
    assign cpu_rvalid  = out_v && !po[RD_LAT-1];
    assign host_rvalid = out_v && po[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (!init_n) begin
            cpu_rd_q  <= '0;
            host_rd_q <= '0;
        end else begin
            if (cpu_rvalid)  cpu_rd_q  <= mem_out;
            if (host_rvalid) host_rd_q <= mem_out;
        end
    end

    assign cpu_rdata  = cpu_rvalid  ? mem_out : cpu_rd_q;
    assign host_rdata = host_rvalid ? mem_out : host_rd_q;

    assign lock_ack = init_n && (state == LOCK);
    assign busy     = cpu_gnt || host_gnt || (|pv);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; the suite runs against RD_LAT=1,2,3
// instances, each with its own behavioural memory (mem[a] = a ^ 8'h3C).
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       init_n;
    logic       cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;

    logic [2:0] cpu_gnt_v, host_gnt_v, cpu_rv_v, host_rv_v;
    logic [2:0] lock_ack_v, wen_v, ren_v, busy_v;
    logic [7:0] cpu_rd_v [3];
    logic [7:0] host_rd_v [3];
    logic [7:0] addr_v [3];
    logic [7:0] min_v [3];

    int n_chk = 0;
    int n_fail = 0;
    int sel = 0;
    int lat = 1;

    for (genvar g = 0; g < 3; g++) begin : u
        logic [7:0] mem_out;
        logic [7:0] mem [256];
        logic [7:0] rp [g+1];

        dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(g + 1)) dut (
            .clk         (clk),
            .init_n      (init_n),
            .cpu_req     (cpu_req),
            .cpu_we      (cpu_we),
            .cpu_addr    (cpu_addr),
            .cpu_wdata   (cpu_wdata),
            .cpu_gnt     (cpu_gnt_v[g]),
            .cpu_rvalid  (cpu_rv_v[g]),
            .cpu_rdata   (cpu_rd_v[g]),
            .host_req    (host_req),
            .host_we     (host_we),
            .host_addr   (host_addr),
            .host_wdata  (host_wdata),
            .host_gnt    (host_gnt_v[g]),
            .host_rvalid (host_rv_v[g]),
            .host_rdata  (host_rd_v[g]),
            .host_lock   (host_lock),
            .lock_ack    (lock_ack_v[g]),
            .addr        (addr_v[g]),
            .mem_in      (min_v[g]),
            .memory_w_en (wen_v[g]),
            .memory_r_en (ren_v[g]),
            .mem_out     (mem_out),
            .busy        (busy_v[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
            for (int i = 0; i <= g; i++) rp[i] = 8'h00;
        end

        always @(posedge clk) begin
            if (wen_v[g]) mem[addr_v[g]] <= min_v[g];
            rp[0] <= ren_v[g] ? mem[addr_v[g]] : 8'h00;
            for (int i = 1; i <= g; i++) rp[i] <= rp[i-1];
        end

        assign mem_out = rp[g];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 8'h00;
        cpu_wdata  = 8'h00;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;
        host_lock  = 1'b0;
    endtask

    task automatic do_reset;
        step;
        init_n = 1'b0;
        idle_inputs;
        step;
        step;
        init_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [6:0] obs;
        step;
        init_n   = 1'b0;
        cpu_req  = 1'b1;
        host_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs = {cpu_gnt_v[sel], host_gnt_v[sel], cpu_rv_v[sel],
                   host_rv_v[sel], wen_v[sel], ren_v[sel], lock_ack_v[sel]};
            n_chk++;
            if (obs !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_idle lat=%0d k=%0d: got %b want 0", lat, k, obs);
            end
            if (k == 2) begin
                n_chk++;
                if (cpu_rd_v[sel] !== 8'h00 || host_rd_v[sel] !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_rdata lat=%0d: got %h/%h want 00/00",
                             lat, cpu_rd_v[sel], host_rd_v[sel]);
                end
            end
            step;
        end
        init_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({cpu_gnt_v[sel], host_gnt_v[sel]} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_winner lat=%0d: got %b want 10",
                     lat, {cpu_gnt_v[sel], host_gnt_v[sel]});
        end
        step;
        idle_inputs;
    endtask

    task automatic test_rd_after_wr;
        do_reset;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h10;
        host_wdata = 8'hA5;
        @(negedge clk);
        n_chk++;
        if (!(host_gnt_v[sel] === 1'b1 && wen_v[sel] === 1'b1 &&
              addr_v[sel] === 8'h10 && min_v[sel] === 8'hA5)) begin
            n_fail++;
            $display("FAIL host_write lat=%0d: gnt=%b wen=%b addr=%h din=%h want 1 1 10 a5",
                     lat, host_gnt_v[sel], wen_v[sel], addr_v[sel], min_v[sel]);
        end
        step;
        host_req = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h10;
        @(negedge clk);
        n_chk++;
        if (!(cpu_gnt_v[sel] === 1'b1 && ren_v[sel] === 1'b1 &&
              wen_v[sel] === 1'b0 && addr_v[sel] === 8'h10)) begin
            n_fail++;
            $display("FAIL cpu_read_gnt lat=%0d: gnt=%b ren=%b wen=%b addr=%h want 1 1 0 10",
                     lat, cpu_gnt_v[sel], ren_v[sel], wen_v[sel], addr_v[sel]);
        end
        step;
        cpu_req = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_chk++;
            if (cpu_rv_v[sel] !== (k == lat) || host_rv_v[sel] !== 1'b0 ||
                busy_v[sel] !== 1'b1 ||
                (k == lat && cpu_rd_v[sel] !== 8'hA5)) begin
                n_fail++;
                $display("FAIL rd_after_wr lat=%0d k=%0d: crv=%b hrv=%b busy=%b data=%h want %b 0 1 a5",
                         lat, k, cpu_rv_v[sel], host_rv_v[sel], busy_v[sel],
                         cpu_rd_v[sel], (k == lat));
            end
            step;
        end
        @(negedge clk);
        n_chk++;
        if (busy_v[sel] !== 1'b0 || addr_v[sel] !== 8'h00 ||
            min_v[sel] !== 8'h00 || wen_v[sel] !== 1'b0 || ren_v[sel] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs lat=%0d: busy=%b addr=%h din=%h wen=%b ren=%b want all 0",
                     lat, busy_v[sel], addr_v[sel], min_v[sel], wen_v[sel], ren_v[sel]);
        end
    endtask

    task automatic test_round_robin;
        logic ev;
        do_reset;
        cpu_req   = 1'b1;
        host_req  = 1'b1;
        cpu_addr  = 8'h00;
        host_addr = 8'h01;
        for (int c = 0; c < 8 + lat; c++) begin
            @(negedge clk);
            if (c < 8) begin
                ev = (c % 2 == 0);
                n_chk++;
                if ({cpu_gnt_v[sel], host_gnt_v[sel]} !== {ev, !ev} ||
                    addr_v[sel] !== 8'(c)) begin
                    n_fail++;
                    $display("FAIL rr_gnt lat=%0d c=%0d: gnt=%b addr=%h want %b%b %h",
                             lat, c, {cpu_gnt_v[sel], host_gnt_v[sel]},
                             addr_v[sel], ev, !ev, 8'(c));
                end
            end
            n_chk++;
            if (c >= lat) begin
                ev = ((c - lat) % 2 == 0);
                if ({cpu_rv_v[sel], host_rv_v[sel]} !== {ev, !ev} ||
                    (ev ? cpu_rd_v[sel] : host_rd_v[sel]) !== (8'(c - lat) ^ 8'h3C)) begin
                    n_fail++;
                    $display("FAIL rr_ret lat=%0d c=%0d: rv=%b data=%h want %b%b %h",
                             lat, c, {cpu_rv_v[sel], host_rv_v[sel]},
                             ev ? cpu_rd_v[sel] : host_rd_v[sel], ev, !ev,
                             8'(c - lat) ^ 8'h3C);
                end
            end else if ({cpu_rv_v[sel], host_rv_v[sel]} !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_early lat=%0d c=%0d: rv=%b want 00",
                         lat, c, {cpu_rv_v[sel], host_rv_v[sel]});
            end
            step;
            if (c < 8) begin
                if (c % 2 == 0) cpu_addr = 8'(c + 2);
                else            host_addr = 8'(c + 2);
            end
            if (c == 7) begin
                cpu_req  = 1'b0;
                host_req = 1'b0;
            end
        end
    endtask

    task automatic test_lock;
        do_reset;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h03;
        @(negedge clk);
        n_chk++;
        if (cpu_gnt_v[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_pre_gnt lat=%0d: got %b want 1", lat, cpu_gnt_v[sel]);
        end
        step;
        cpu_addr  = 8'h05;
        host_lock = 1'b1;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (cpu_gnt_v[sel] !== 1'b0 || lock_ack_v[sel] !== (k == lat + 2) ||
                cpu_rv_v[sel] !== (k == lat) ||
                (k == lat && cpu_rd_v[sel] !== 8'h3F)) begin
                n_fail++;
                $display("FAIL lock_drain lat=%0d k=%0d: gnt=%b ack=%b crv=%b data=%h want 0 %b %b 3f",
                         lat, k, cpu_gnt_v[sel], lock_ack_v[sel], cpu_rv_v[sel],
                         cpu_rd_v[sel], (k == lat + 2), (k == lat));
            end
            step;
        end
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h20;
        @(negedge clk);
        n_chk++;
        if (host_gnt_v[sel] !== 1'b1 || cpu_gnt_v[sel] !== 1'b0 ||
            lock_ack_v[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_host_gnt lat=%0d: hg=%b cg=%b ack=%b want 1 0 1",
                     lat, host_gnt_v[sel], cpu_gnt_v[sel], lock_ack_v[sel]);
        end
        step;
        host_req = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_chk++;
            if (host_rv_v[sel] !== (k == lat) || cpu_rv_v[sel] !== 1'b0 ||
                cpu_gnt_v[sel] !== 1'b0 ||
                (k == lat && host_rd_v[sel] !== 8'h1C)) begin
                n_fail++;
                $display("FAIL lock_host_rd lat=%0d k=%0d: hrv=%b crv=%b cg=%b data=%h want %b 0 0 1c",
                         lat, k, host_rv_v[sel], cpu_rv_v[sel], cpu_gnt_v[sel],
                         host_rd_v[sel], (k == lat));
            end
            step;
        end
    endtask

    task automatic test_unlock;
        host_lock = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cpu_gnt_v[sel] !== 1'b0 || lock_ack_v[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL unlock_same lat=%0d: cg=%b ack=%b want 0 1",
                     lat, cpu_gnt_v[sel], lock_ack_v[sel]);
        end
        step;
        @(negedge clk);
        n_chk++;
        if (cpu_gnt_v[sel] !== 1'b1 || lock_ack_v[sel] !== 1'b0 ||
            addr_v[sel] !== 8'h05) begin
            n_fail++;
            $display("FAIL unlock_gnt lat=%0d: cg=%b ack=%b addr=%h want 1 0 05",
                     lat, cpu_gnt_v[sel], lock_ack_v[sel], addr_v[sel]);
        end
        step;
        cpu_req = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_chk++;
            if (cpu_rv_v[sel] !== (k == lat) ||
                (k == lat && cpu_rd_v[sel] !== 8'h39)) begin
                n_fail++;
                $display("FAIL unlock_rd lat=%0d k=%0d: crv=%b data=%h want %b 39",
                         lat, k, cpu_rv_v[sel], cpu_rd_v[sel], (k == lat));
            end
            step;
        end
    endtask

    task automatic test_reset_mid_read;
        do_reset;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h02;
        @(negedge clk);
        n_chk++;
        if (cpu_gnt_v[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_gnt lat=%0d: got %b want 1", lat, cpu_gnt_v[sel]);
        end
        step;
        cpu_req = 1'b0;
        init_n  = 1'b0;
        @(negedge clk);
        step;
        init_n = 1'b1;
        for (int k = 0; k < lat + 2; k++) begin
            @(negedge clk);
            n_chk++;
            if ({cpu_rv_v[sel], host_rv_v[sel]} !== 2'b00 ||
                cpu_rd_v[sel] !== 8'h00) begin
                n_fail++;
                $display("FAIL midrst_rv lat=%0d k=%0d: rv=%b data=%h want 00 00",
                         lat, k, {cpu_rv_v[sel], host_rv_v[sel]}, cpu_rd_v[sel]);
            end
            step;
        end
    endtask

    initial begin
        init_n = 1'b0;
        idle_inputs;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            lat = s + 1;
            test_reset;
            test_rd_after_wr;
            test_round_robin;
            test_lock;
            test_unlock;
            test_reset_mid_read;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
